// File: rtl/character_gen.sv
// Transmit side of the '#...?' character-stream protocol: one ASCII character per
// valid/ready beat, framing N words of "BUA" plus a configurable run of extra 'A's.
module character_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned EXT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_words,
  input  logic [EXT_W-1:0] n_extra,
  output logic [7:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    IDLE, HASH, CB, CU, CA, CX, SP, QM, DONE
  } state_t;

  localparam logic [CNT_W-1:0] WORD_ONE = CNT_W'(1);
  localparam logic [EXT_W-1:0] EXT_ONE  = EXT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] word_left, word_n;
  logic [EXT_W-1:0] a_left, a_n;
  logic [EXT_W-1:0] extra_lat, extra_n;
  logic [7:0]       out_d;
  logic             valid_d;
  logic             beat;

  assign beat = out_valid && out_ready;

  always_comb begin
    state_n = state;
    word_n  = word_left;
    a_n     = a_left;
    extra_n = extra_lat;
    unique case (state)
      IDLE: if (start) begin
        word_n  = n_words;
        a_n     = n_extra;
        extra_n = n_extra;
        state_n = HASH;
      end
      HASH: if (beat) state_n = (word_left != '0) ? CB : QM;
      CB:   if (beat) state_n = CU;
      CU:   if (beat) state_n = CA;
      CA: if (beat) begin
        word_n = word_left - WORD_ONE;
        if (a_left != '0)     state_n = CX;
        else if (word_n != '0) state_n = SP;
        else                   state_n = QM;
      end
      // word_left was already decremented on the CA beat of this word
      CX: if (beat) begin
        a_n = a_left - EXT_ONE;
        if (a_n == '0) state_n = (word_left != '0) ? SP : QM;
      end
      SP: if (beat) begin
        a_n     = extra_lat;
        state_n = CB;
      end
      QM:      if (beat) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output character is registered from the next state so it is stable while stalled
  always_comb begin
    out_d   = 8'h00;
    valid_d = 1'b1;
    unique case (state_n)
      HASH:       out_d = 8'h23;
      CB:         out_d = 8'h42;
      CU:         out_d = 8'h55;
      CA, CX:     out_d = 8'h41;
      SP:         out_d = 8'h20;
      QM:         out_d = 8'h3F;
      default:    valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      word_left <= '0;
      a_left    <= '0;
      extra_lat <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      word_left <= word_n;
      a_left    <= a_n;
      extra_lat <= extra_n;
      out       <= out_d;
      out_valid <= valid_d;
      busy      <= valid_d;
      done      <= (state_n == DONE);
    end
  end

endmodule
